prefetch_req_queue: RTL
=======================

PREFETCH_REQ_QUEUE -- requirements
Module: prefetch_req_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 40, meaning the physical address width (coreMaxAddrBits).
REQ-002 SHALL have parameter BLK_LG, default 6, meaning log2 of the cache block size in bytes.
REQ-003 SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries (power of two, at least 2).
REQ-004 SHALL have parameter HIST, default 8, meaning the number of history entries (power of two).
REQ-005 SHALL have port clock  in  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port flush  in  1  clears queued and history state.
REQ-008 SHALL have port in_valid  in  1  a prefetch request is presented by the next-line prefetcher.
REQ-009 SHALL have port in_ready  out  1  tied to 1; the block never back-pressures.
REQ-010 SHALL have port in_addr  in  ADDR_W  request address.
REQ-011 SHALL have port in_cmd  in  5  M_PFR or M_PFW.
REQ-012 SHALL have port out_valid  out  1  head entry available.
REQ-013 SHALL have port out_ready  in  1  MSHR file can allocate.
REQ-014 SHALL have port out_addr  out  ADDR_W  block-aligned address, low BLK_LG bits zero.
REQ-015 SHALL have port out_cmd  out  5  command of the head entry.
REQ-016 SHALL have port drop_cnt  out  16  saturating count of dropped requests.

Function
REQ-017 SHALL define the line address as in_addr[ADDR_W-1:BLK_LG], and SHALL perform all comparisons on line addresses.
REQ-018 SHALL define accept as in_valid AND NOT flush; push as accept AND NOT dup AND (count<DEPTH OR out fire in the same cycle); pop as out_valid AND out_ready.
REQ-019 SHALL set dup when the line matches any valid FIFO entry, including a head being popped in the same cycle, or any valid history entry (history only with the macro defined).
REQ-020 SHALL, on a FIFO dup match (other than the popping head) where the entry holds M_PFR and in_cmd is M_PFW, upgrade that entry's cmd to M_PFW without pushing.
REQ-021 SHALL increment drop_cnt by 1 (saturating at 0xFFFF) for each accepted request that is not pushed, whether dup or full; a cmd upgrade also counts as a drop.
REQ-022 SHALL make a pushed entry visible on out_valid in the cycle after the push (1-cycle latency), with out_* driven from registers or FIFO storage and no combinational in-to-out path.
REQ-023 SHALL deliver entries in FIFO order, with read and write pointers wrapping modulo DEPTH; count SHALL range 0..DEPTH.
REQ-024 SHALL, when full with a simultaneous pop, accept the push in the same cycle, leaving count unchanged.
REQ-025 SHALL hold out_addr and out_cmd stable while out_valid=1 and out_ready=0, except for a REQ-020 upgrade of the head entry's cmd.
REQ-026 SHALL, when flush=1, clear FIFO count/pointers and all history valid bits next cycle, ignore in_valid, suppress any pop (out_ready ignored), and leave drop_cnt unchanged.

Reset
REQ-027 SHALL, on reset, set out_valid=0, out_addr=0, out_cmd=0, drop_cnt=0, count=0, pointers=0 and all history valid bits=0.
REQ-028 SHALL give reset priority over flush and all other activity; reset mid-stream SHALL discard queued entries without emitting them.

Configuration
REQ-029 SHALL, with macro PF_QUEUE_HISTORY_EN defined, include a HIST-entry history ring that writes the line address at each pop at a round-robin pointer (wrapping, oldest overwritten) and participates in dup per REQ-019.
REQ-030 SHALL, without PF_QUEUE_HISTORY_EN, contain no history storage and perform dup on FIFO entries only.

Verification
REQ-031 SHALL cover: with out_ready=0, push 0x1000 PFR then 0x1020 PFW -> one entry, cmd M_PFW, drop_cnt=1.
REQ-032 SHALL cover: with out_ready=0, push 5 distinct lines 0x1000..0x1100 step 0x40 -> 4 queued, drop_cnt=1; out_ready=1 -> outputs 0x1000,0x1040,0x1080,0x10C0 in order.
REQ-033 SHALL cover: with PF_QUEUE_HISTORY_EN, pop 0x2000, then push 0x2010 -> dropped, drop_cnt+1; after 8 further distinct pops, push 0x2000 -> accepted.
REQ-034 SHALL cover: while full, pop and push 0x3000 in the same cycle -> count stays 4, 0x3000 emerges last.
REQ-035 SHALL cover: flush with 3 entries queued and in_valid=1 -> next cycle out_valid=0, drop_cnt unchanged, input not queued.
REQ-036 SHALL cover: 70000 dup requests -> drop_cnt=0xFFFF.

Source files
------------

// File: rtl/prefetch_req_queue.sv
// Prefetch request queue: line-deduplicating FIFO between the next-line prefetcher and the MSHR file.
// Optional recently-issued history filter enabled by macro PF_QUEUE_HISTORY_EN.
module prefetch_req_queue #(
   parameter int ADDR_W = 40,
   parameter int BLK_LG = 6,
   parameter int DEPTH  = 4,
   parameter int HIST   = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [4:0]        in_cmd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [4:0]        out_cmd,
   output logic [15:0]       drop_cnt
);

   localparam int LINE_W = ADDR_W - BLK_LG;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
   localparam logic [4:0] M_PFR = 5'b00010;
   localparam logic [4:0] M_PFW = 5'b00011;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HIST < 2 || (HIST & (HIST - 1)) != 0) begin : g_bad_param
      $error("prefetch_req_queue: DEPTH and HIST must be powers of two, at least 2");
   end

   logic [LINE_W-1:0] line_mem [DEPTH];
   logic [4:0]        cmd_mem  [DEPTH];
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count;
   logic [PTR_W-1:0]  slot_offs [DEPTH];
   logic [DEPTH-1:0]  fifo_hit, upgrade;
   logic [LINE_W-1:0] in_line;
   logic              hist_hit, accept, dup, push, pop;
   logic              unused_low_bits;

   assign in_line         = in_addr[ADDR_W-1:BLK_LG];
   assign unused_low_bits = ^in_addr[BLK_LG-1:0];
   assign in_ready        = 1'b1;

   assign out_valid = (count != '0);
   assign out_addr  = out_valid ? {line_mem[rd_ptr], {BLK_LG{1'b0}}} : '0;
   assign out_cmd   = out_valid ? cmd_mem[rd_ptr] : '0;

   assign accept = in_valid && !flush;
   assign pop    = out_valid && out_ready && !flush;
   assign dup    = (|fifo_hit) || hist_hit;
   assign push   = accept && !dup && ((count < FULL) || pop);

   // A slot is live when its distance from the read pointer is below count.
   always_comb begin
      fifo_hit = '0;
      upgrade  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         slot_offs[i] = PTR_W'(i) - rd_ptr;
         fifo_hit[i]  = ({1'b0, slot_offs[i]} < count) && (line_mem[i] == in_line);
         upgrade[i]   = accept && fifo_hit[i] && !(pop && (PTR_W'(i) == rd_ptr))
                        && (cmd_mem[i] == M_PFR) && (in_cmd == M_PFW);
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   // Storage needs no reset: outputs are gated by out_valid.
   always_ff @(posedge clock) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!reset && push && (wr_ptr == PTR_W'(i))) begin
            line_mem[i] <= in_line;
            cmd_mem[i]  <= in_cmd;
         end else if (!reset && upgrade[i]) begin
            cmd_mem[i] <= M_PFW;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset)                                  drop_cnt <= '0;
      else if (accept && !push && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
   end

`ifdef PF_QUEUE_HISTORY_EN
   localparam int HPTR_W = $clog2(HIST);

   logic [LINE_W-1:0] hist_line [HIST];
   logic [HIST-1:0]   hist_vld;
   logic [HPTR_W-1:0] hist_ptr;

   always_comb begin
      hist_hit = 1'b0;
      for (int unsigned i = 0; i < HIST; i++) begin
         if (hist_vld[i] && (hist_line[i] == in_line)) hist_hit = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         hist_vld <= '0;
         hist_ptr <= '0;
      end else if (pop) begin
         hist_line[hist_ptr] <= line_mem[rd_ptr];
         hist_vld[hist_ptr]  <= 1'b1;
         hist_ptr            <= hist_ptr + 1'b1;
      end
   end
`else
   assign hist_hit = 1'b0;
`endif

endmodule
